// File: rtl/instr_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_counter                                                      |
// | Program counter, conditional branching and return-address stack.   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module instr_counter #(
  parameter int AW       = 15,
  parameter int DEPTH    = 16,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sCOU,
  input  logic [3:0]             mOperCOU,
  input  logic [AW-1:0]          dataAddr,
  input  logic [1:0]             creg1,
  input  logic                   aeq,
  input  logic                   cmpEq,
  input  logic                   cmpGt,
  input  logic                   cmpLt,
  input  logic                   hlt,
  input  logic                   resume,
  input  logic                   prst,
  output logic [AW-1:0]          pc,
  output logic                   fetch,
  output logic                   taken,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   halted,
  output logic                   fault
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SPW = PW + 1;

  localparam logic [AW-1:0]  c_RESET_PC = RESET_PC[AW-1:0];
  localparam logic [SPW-1:0] c_DEPTH    = SPW'(DEPTH);

  localparam logic [3:0] c_OP_JEQ  = 4'd1;
  localparam logic [3:0] c_OP_JGT  = 4'd2;
  localparam logic [3:0] c_OP_JLT  = 4'd3;
  localparam logic [3:0] c_OP_JMP  = 4'd5;
  localparam logic [3:0] c_OP_NEXT = 4'd6;
  localparam logic [3:0] c_OP_CALL = 4'd7;
  localparam logic [3:0] c_OP_RET  = 4'd8;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t         r_state, w_state_nx;
  logic [AW-1:0]  r_pc, w_pc_nx;
  logic [SPW-1:0] r_sp, w_sp_nx;
  logic           r_fetch, w_fetch_nx;
  logic           r_taken, w_taken_nx;
  logic           w_push;
  logic [AW-1:0]  r_stack [DEPTH];

  logic [AW-1:0]  w_pc_inc;
  logic [AW-1:0]  w_target;
  logic [PW-1:0]  w_rd_idx;
  logic           w_cond;
  logic           w_unused;

  assign w_unused = creg1[1];
  assign w_pc_inc = r_pc + AW'(1);
  assign w_target = creg1[0] ? (r_pc + dataAddr) : dataAddr;
  assign w_rd_idx = PW'(r_sp - SPW'(1));

  always_comb begin
    w_cond = 1'b0;
    case (mOperCOU)
      c_OP_JEQ: w_cond = cmpEq;
      c_OP_JGT: w_cond = cmpGt | (aeq & cmpEq);
      c_OP_JLT: w_cond = cmpLt | (aeq & cmpEq);
      default:  w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_sp_nx    = r_sp;
    w_fetch_nx = 1'b0;
    w_taken_nx = 1'b0;
    w_push     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (sCOU) begin
          case (mOperCOU)
            c_OP_NEXT: begin
              w_pc_nx    = w_pc_inc;
              w_fetch_nx = 1'b1;
              w_taken_nx = (w_pc_inc == '0);
            end
            c_OP_JMP: begin
              w_pc_nx    = w_target;
              w_fetch_nx = 1'b1;
              w_taken_nx = 1'b1;
            end
            c_OP_JEQ, c_OP_JGT, c_OP_JLT: begin
              w_pc_nx    = w_cond ? w_target : w_pc_inc;
              w_fetch_nx = 1'b1;
              w_taken_nx = w_cond | (w_pc_inc == '0);
            end
            c_OP_CALL: begin
              if (r_sp == c_DEPTH) begin
                w_state_nx = S_FAULT;
              end else begin
                w_push     = 1'b1;
                w_sp_nx    = r_sp + SPW'(1);
                w_pc_nx    = w_target;
                w_fetch_nx = 1'b1;
                w_taken_nx = 1'b1;
              end
            end
            c_OP_RET: begin
              if (r_sp == '0) begin
                w_state_nx = S_FAULT;
              end else begin
                w_sp_nx    = r_sp - SPW'(1);
                w_pc_nx    = r_stack[w_rd_idx];
                w_fetch_nx = 1'b1;
                w_taken_nx = 1'b1;
              end
            end
            default: ;
          endcase
        end
        // A faulting op outranks a simultaneous halt request
        if (hlt && (w_state_nx != S_FAULT)) begin
          w_state_nx = S_HALTED;
        end
      end
      S_HALTED: begin
        if (resume) begin
          w_state_nx = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= c_RESET_PC;
      r_sp    <= '0;
      r_fetch <= 1'b0;
      r_taken <= 1'b0;
    end else if (prst) begin
      r_state <= S_RUN;
      r_pc    <= c_RESET_PC;
      r_sp    <= '0;
      r_fetch <= 1'b1;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_sp    <= w_sp_nx;
      r_fetch <= w_fetch_nx;
      r_taken <= w_taken_nx;
    end
  end

  // Stack storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push && !prst) begin
      r_stack[r_sp[PW-1:0]] <= w_pc_inc;
    end
  end

  assign pc     = r_pc;
  assign sp     = r_sp;
  assign fetch  = r_fetch;
  assign taken  = r_taken;
  assign halted = (r_state == S_HALTED);
  assign fault  = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_instr_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_counter                                                   |
// | Scoreboard bench with a queue-based reference model.               |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_instr_counter;

  localparam int AW       = 15;
  localparam int DEPTH    = 16;
  localparam int RESET_PC = 0;
  localparam int SPW      = $clog2(DEPTH) + 1;
  localparam int MOD      = 1 << AW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sCOU = 1'b0;
  logic [3:0]     mOperCOU = '0;
  logic [AW-1:0]  dataAddr = '0;
  logic [1:0]     creg1 = '0;
  logic           aeq = 1'b0;
  logic           cmpEq = 1'b0;
  logic           cmpGt = 1'b0;
  logic           cmpLt = 1'b0;
  logic           hlt = 1'b0;
  logic           resume = 1'b0;
  logic           prst = 1'b0;
  logic [AW-1:0]  pc;
  logic           fetch;
  logic           taken;
  logic [SPW-1:0] sp;
  logic           halted;
  logic           fault;

  instr_counter #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .sCOU(sCOU), .mOperCOU(mOperCOU), .dataAddr(dataAddr),
    .creg1(creg1), .aeq(aeq), .cmpEq(cmpEq), .cmpGt(cmpGt), .cmpLt(cmpLt),
    .hlt(hlt), .resume(resume), .prst(prst), .pc(pc), .fetch(fetch),
    .taken(taken), .sp(sp), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int sp;
    int fetch;
    int taken;
    int halted;
    int fault;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int   m_pc = RESET_PC;
  int   m_stack[$];
  bit   m_halted = 1'b0;
  bit   m_fault  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("pc", int'(pc), e.pc);
    chk("sp", int'(sp), e.sp);
    chk("fetch", int'(fetch), e.fetch);
    chk("taken", int'(taken), e.taken);
    chk("halted", int'(halted), e.halted);
    chk("fault", int'(fault), e.fault);
  endtask

  // Monitor: every edge presents a new output set; compare against queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk_all(e);
      end
    end
  end

  // f = {aeq, cmpEq, cmpGt, cmpLt}; c = {hlt, resume, prst}
  task automatic issue(input bit s, input int op, input int a, input bit rel,
                       input bit [3:0] f, input bit [2:0] c);
    exp_t e;
    int   inc, tgt;
    bit   cond, flt;
    @(negedge clk);
    sCOU = s; mOperCOU = 4'(op); dataAddr = AW'(a); creg1 = {1'b0, rel};
    {aeq, cmpEq, cmpGt, cmpLt} = f;
    {hlt, resume, prst} = c;
    e.fetch = 0;
    e.taken = 0;
    flt     = 1'b0;
    if (c[0]) begin
      m_pc = RESET_PC;
      m_stack.delete();
      m_halted = 1'b0;
      m_fault  = 1'b0;
      e.fetch  = 1;
    end else if (m_fault) begin
    end else if (m_halted) begin
      if (c[1]) m_halted = 1'b0;
    end else begin
      if (s) begin
        inc = (m_pc + 1) % MOD;
        tgt = rel ? (m_pc + a) % MOD : a;
        case (op)
          6: begin m_pc = inc; e.fetch = 1; e.taken = (inc == 0); end
          5: begin m_pc = tgt; e.fetch = 1; e.taken = 1; end
          1, 2, 3: begin
            if (op == 1)      cond = f[2];
            else if (op == 2) cond = f[1] | (f[3] & f[2]);
            else              cond = f[0] | (f[3] & f[2]);
            m_pc    = cond ? tgt : inc;
            e.fetch = 1;
            e.taken = cond ? 1 : int'(inc == 0);
          end
          7: begin
            if (m_stack.size() == DEPTH) flt = 1'b1;
            else begin m_stack.push_back(inc); m_pc = tgt; e.fetch = 1; e.taken = 1; end
          end
          8: begin
            if (m_stack.size() == 0) flt = 1'b1;
            else begin m_pc = m_stack.pop_back(); e.fetch = 1; e.taken = 1; end
          end
          default: ;
        endcase
      end
      if (flt) m_fault = 1'b1;
      else if (c[2]) m_halted = 1'b1;
    end
    e.pc     = m_pc;
    e.sp     = m_stack.size();
    e.halted = m_halted;
    e.fault  = m_fault;
    q.push_back(e);
  endtask

  task automatic idle();
    issue(1'b0, 0, 0, 1'b0, 4'b0, 3'b0);
  endtask

  // Asynchronous reset applied between edges and checked before any clock edge
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    sCOU = 1'b0; hlt = 1'b0; resume = 1'b0; prst = 1'b0;
    #1 rst = 1'b1;
    #1;
    m_pc = RESET_PC; m_stack.delete(); m_halted = 1'b0; m_fault = 1'b0;
    e.pc = RESET_PC; e.sp = 0; e.fetch = 0; e.taken = 0; e.halted = 0; e.fault = 0;
    chk_all(e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    int   ops[9] = '{1, 2, 3, 5, 6, 7, 7, 8, 8};
    int   op;
    bit   pr, h, res;
    repeat (2) @(negedge clk);
    e.pc = RESET_PC; e.sp = 0; e.fetch = 0; e.taken = 0; e.halted = 0; e.fault = 0;
    chk_all(e);
    rst = 1'b0;

    repeat (3) issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b0);
    idle();
    issue(1'b1, 5, 'h10, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 1, 'h100, 1'b0, 4'b0000, 3'b0);
    issue(1'b1, 1, 'h100, 1'b0, 4'b0100, 3'b0);
    issue(1'b1, 2, 'h200, 1'b0, 4'b0100, 3'b0);
    issue(1'b1, 2, 'h200, 1'b0, 4'b1100, 3'b0);
    issue(1'b1, 3, 'h300, 1'b0, 4'b0001, 3'b0);
    issue(1'b1, 5, 'h5, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 5, 'h7FFE, 1'b1, 4'b0, 3'b0);
    issue(1'b1, 5, 'h7FFF, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 4, 'h123, 1'b0, 4'b0, 3'b0);

    issue(1'b1, 5, 'h40, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 7, 'h200, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 8, 'h555, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 8, 0, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b100);
    issue(1'b1, 5, 'h77, 1'b0, 4'b0, 3'b010);
    issue(1'b0, 0, 0, 1'b0, 4'b0, 3'b001);

    for (int i = 0; i <= DEPTH; i++)
      issue(1'b1, 7, int'($urandom_range(0, MOD - 1)), 1'b0, 4'b0, 3'b0);
    issue(1'b1, 8, 0, 1'b0, 4'b0, 3'b0);
    issue(1'b1, 7, 'h10, 1'b0, 4'b0, 3'b001);
    issue(1'b1, 8, 0, 1'b0, 4'b0, 3'b0);

    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b100);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b000);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b010);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b000);
    issue(1'b1, 6, 0, 1'b0, 4'b0, 3'b010);
    issue(1'b1, 7, 'h30, 1'b1, 4'b0, 3'b0);

    do_reset();

    for (int i = 0; i < 800; i++) begin
      op  = ($urandom % 4 == 0) ? int'($urandom % 16) : ops[$urandom % 9];
      pr  = m_fault ? ($urandom % 4 == 0) : ($urandom % 60 == 0);
      h   = ($urandom % 25 == 0);
      res = ($urandom % 3 == 0);
      issue(($urandom % 5) != 0, op, int'($urandom_range(0, MOD - 1)), 1'($urandom % 2),
            4'($urandom), {h, res, pr});
    end

    repeat (2) idle();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
